// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: state codes, opcodes (inst[6:2]),
// datapath select/ALU encodings and the per-state control bundle.
package multicycle_control_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_e;

    localparam logic [4:0] OPC_LOAD    = 5'b00000;
    localparam logic [4:0] OPC_STORE   = 5'b01000;
    localparam logic [4:0] OPC_ARITH_R = 5'b01100;
    localparam logic [4:0] OPC_ARITH_I = 5'b00100;
    localparam logic [4:0] OPC_BRANCH  = 5'b11000;
    localparam logic [4:0] OPC_LUI     = 5'b01101;
    localparam logic [4:0] OPC_AUIPC   = 5'b00101;
    localparam logic [4:0] OPC_JAL     = 5'b11011;
    localparam logic [4:0] OPC_JALR    = 5'b11001;
    localparam logic [4:0] OPC_SYSTEM  = 5'b11100;

    localparam logic [1:0] SRC_A_PC     = 2'd0;
    localparam logic [1:0] SRC_A_RS1    = 2'd1;
    localparam logic [1:0] SRC_A_ZERO   = 2'd2;
    localparam logic [1:0] SRC_A_OLD_PC = 2'd3;

    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_IMM  = 2'd1;
    localparam logic [1:0] SRC_B_FOUR = 2'd2;

    localparam logic [1:0] ALU_ADD     = 2'd0;
    localparam logic [1:0] ALU_BRANCH  = 2'd1;
    localparam logic [1:0] ALU_FUNCT_R = 2'd2;
    localparam logic [1:0] ALU_FUNCT_I = 2'd3;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] wb_sel;
    } ctrl_t;

    function automatic logic op_supported(input logic [4:0] opc);
        case (opc)
            OPC_LOAD, OPC_STORE, OPC_ARITH_R, OPC_ARITH_I, OPC_BRANCH,
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: op_supported = 1'b1;
            default:                               op_supported = 1'b0;
        endcase
    endfunction

    function automatic state_e exec_next(input logic [4:0] opc);
        case (opc)
            OPC_LOAD, OPC_STORE:                             exec_next = ST_MEM;
            OPC_ARITH_R, OPC_ARITH_I, OPC_LUI, OPC_AUIPC:    exec_next = ST_WB;
            default:                                         exec_next = ST_FETCH;
        endcase
    endfunction

    // JAL/JALR write the link register in EXEC itself, before the PC update lands.
    function automatic ctrl_t exec_ctrl(input logic [4:0] opc);
        ctrl_t c;
        c = '0;
        case (opc)
            OPC_LOAD, OPC_STORE: begin
                c.alu_src_a = SRC_A_RS1;
                c.alu_src_b = SRC_B_IMM;
                c.alu_op    = ALU_ADD;
            end
            OPC_ARITH_R: begin
                c.alu_src_a = SRC_A_RS1;
                c.alu_src_b = SRC_B_RS2;
                c.alu_op    = ALU_FUNCT_R;
            end
            OPC_ARITH_I: begin
                c.alu_src_a = SRC_A_RS1;
                c.alu_src_b = SRC_B_IMM;
                c.alu_op    = ALU_FUNCT_I;
            end
            OPC_LUI: begin
                c.alu_src_a = SRC_A_ZERO;
                c.alu_src_b = SRC_B_IMM;
            end
            OPC_AUIPC: begin
                c.alu_src_a = SRC_A_OLD_PC;
                c.alu_src_b = SRC_B_IMM;
            end
            OPC_BRANCH: begin
                c.alu_src_a     = SRC_A_RS1;
                c.alu_src_b     = SRC_B_RS2;
                c.alu_op        = ALU_BRANCH;
                c.pc_write_cond = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                c.alu_src_a = (opc == OPC_JAL) ? SRC_A_OLD_PC : SRC_A_RS1;
                c.alu_src_b = SRC_B_IMM;
                c.pc_write  = 1'b1;
                c.reg_write = 1'b1;
                c.wb_sel    = WB_PC;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_unit_mem_wait_timer.sv
// Memory wait-state timer: counts consecutive no-ack cycles and flags expiry on the
// 2**W-1'th one, when the count would reach all-ones.
module mem_wait_timer #(
    parameter int W = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic clr_i,
    output logic expired_o
);
    localparam logic [W-1:0] LAST = {{(W-1){1'b1}}, 1'b0};

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    assign expired_o = inc_i && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM driving datapath selects/enables and the shared memory port.
//   state  | meaning
//   IDLE   | out of reset, start fetching next cycle
//   FETCH  | instruction read; on ack load IR and PC+4
//   DECODE | latch opcode, precompute branch/jump target
//   EXEC   | ALU operation; branches and jumps finish here
//   MEM    | data load/store handshake
//   WB     | register file write
//   TRAP   | illegal opcode or bus timeout, held until reset
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int OP_W     = 5,
    parameter int ALU_OP_W = 2,
    parameter int TMO_W    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OP_W-1:0]     op,
    input  logic                stall,
    input  logic                mem_ack,
    output logic                mem_req,
    output logic                mem_we,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                reg_write,
    output logic [1:0]          wb_sel,
    output logic                illegal,
    output logic                bus_err,
    output logic [2:0]          state_o
);
    state_e          state_q, state_d;
    logic [OP_W-1:0] op_q, op_d;
    logic            illegal_q, illegal_d;
    logic            bus_err_q, bus_err_d;
    logic            waiting, ack_eff;
    logic            tmo_inc, tmo_clr, tmo_expired;
    ctrl_t           ctrl;

    assign waiting = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign ack_eff = waiting && mem_ack && !stall;
    assign tmo_inc = waiting && !stall && !mem_ack;
    assign tmo_clr = ack_eff || (state_d != state_q);

    mem_wait_timer #(.W(TMO_W)) u_mem_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_i     (tmo_inc),
        .clr_i     (tmo_clr),
        .expired_o (tmo_expired)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q | tmo_expired;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (ack_eff) begin
                    state_d = ST_DECODE;
                end else if (tmo_expired) begin
                    state_d = ST_TRAP;
                end
            end
            ST_DECODE: begin
                if (!stall) begin
                    op_d = op;
                    if (op_supported(5'(op))) begin
                        state_d = ST_EXEC;
                    end else begin
                        state_d   = ST_TRAP;
                        illegal_d = 1'b1;
                    end
                end
            end
            ST_EXEC: begin
                if (!stall) begin
                    state_d = exec_next(5'(op_q));
                end
            end
            ST_MEM: begin
                if (ack_eff) begin
                    state_d = (5'(op_q) == OPC_STORE) ? ST_FETCH : ST_WB;
                end else if (tmo_expired) begin
                    state_d = ST_TRAP;
                end
            end
            ST_WB: begin
                if (!stall) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_TRAP;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            ST_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.alu_src_a = SRC_A_PC;
                ctrl.alu_src_b = SRC_B_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.ir_write  = mem_ack;
                ctrl.pc_write  = mem_ack;
            end
            ST_DECODE: begin
                ctrl.alu_src_a = SRC_A_OLD_PC;
                ctrl.alu_src_b = SRC_B_IMM;
            end
            ST_EXEC: ctrl = exec_ctrl(5'(op_q));
            ST_MEM: begin
                ctrl.mem_req = 1'b1;
                ctrl.mem_we  = (5'(op_q) == OPC_STORE);
            end
            ST_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.wb_sel    = (5'(op_q) == OPC_LOAD) ? WB_MEM : WB_ALU;
            end
            default: ctrl = '0;
        endcase
        // Stall freezes side effects but leaves selects stable for the datapath.
        if (stall) begin
            ctrl.mem_req       = 1'b0;
            ctrl.ir_write      = 1'b0;
            ctrl.pc_write      = 1'b0;
            ctrl.pc_write_cond = 1'b0;
            ctrl.reg_write     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign mem_req       = ctrl.mem_req;
    assign mem_we        = ctrl.mem_we;
    assign ir_write      = ctrl.ir_write;
    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ALU_OP_W'(ctrl.alu_op);
    assign reg_write     = ctrl.reg_write;
    assign wb_sel        = ctrl.wb_sel;
    assign illegal       = illegal_q;
    assign bus_err       = bus_err_q;
    assign state_o       = state_q;

endmodule
